// File: rtl/ram_pkg.sv
// Shared types and constants for the clearable banked RAM.
// State encoding and depth helper used by ram_clr.
package ram_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// One bank of the banked RAM: synchronous write, combinational read.
// No reset; contents are zeroed by the clear sequencer in the top.
module ram_bank #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             load,
  input  logic [AW-1:0]    address,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] mem_q [1 << AW];

  // write port: one word per enabled edge
  always_ff @(posedge clk) begin
    if (load) mem_q[address] <= in;
  end

  assign out = mem_q[address];

endmodule

// File: rtl/ram_clr.sv
// Parametrised banked RAM with a clear sequencer that zeroes every
// word after reset or on request, holding busy while it runs.
module ram_clr
  import ram_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6,
  parameter int BANK_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int DEPTH  = depth_of(ADDR_W);
  localparam int WORD_W = ADDR_W - BANK_W;
  localparam int BA_W   = (WORD_W > 0) ? WORD_W : 1;
  localparam int NB     = 1 << BANK_W;
  localparam logic [ADDR_W-1:0] WMASK =
    ADDR_W'((1 << WORD_W) - 1);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] wr_bank;
  logic [BA_W-1:0]   wr_word;
  logic [ADDR_W-1:0] rd_bank;
  logic [BA_W-1:0]   rd_word;
  logic [WIDTH-1:0]  bank_out [NB];

  assign busy = (state_q == ST_CLEAR);

  // sequencer: reset or clear restarts a sweep from word 0
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (cnt_q == LAST) state_q <= ST_IDLE;
          else cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          if (clear) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  // sequencer owns the write port while clearing; clear beats load
  always_comb begin
    wr_en   = !reset && (busy || (load && !clear));
    wr_addr = busy ? cnt_q : address;
    wr_data = busy ? '0 : in;
    wr_bank = wr_addr >> WORD_W;
    wr_word = BA_W'(wr_addr & WMASK);
    rd_bank = address >> WORD_W;
    rd_word = BA_W'(address & WMASK);
  end

  for (genvar i = 0; i < NB; i++) begin : g_bank
    logic      [BA_W-1:0] b_addr;
    assign b_addr = busy ? wr_word : rd_word;
    ram_bank #(
      .WIDTH (WIDTH),
      .AW    (BA_W)
    ) u_bank (
      .clk     (clk),
      .load    (wr_en && (wr_bank == ADDR_W'(i))),
      .address (b_addr),
      .in      (wr_data),
      .out     (bank_out[i])
    );
  end

  // output mux: selected bank in idle, zero while clearing
  always_comb begin
    out = '0;
    if (!busy) begin
      for (int i = 0; i < NB; i++) begin
        if (rd_bank == ADDR_W'(i)) out = bank_out[i];
      end
    end
  end

endmodule

// File: tb/tb_ram_clr.sv
// Directed bench for ram_clr: vector table plus
// hand-written clear/reset sequences.
module tb_ram_clr;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [5:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_clr #(
    .WIDTH  (16),
    .ADDR_W (6),
    .BANK_W (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .busy    (busy)
  );

  typedef struct {
    logic        ld;
    logic        clr;
    logic [5:0]  addr;
    logic [15:0] din;
    logic [15:0] pre;
    logic [15:0] post;
    logic        bsy;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // counts busy cycles from now, with a bound
  task automatic wait_idle(output int n, output logic nz);
    n  = 0;
    nz = 1'b0;
    while (busy && n < 200) begin
      if (out !== 16'h0) nz = 1'b1;
      n++;
      tick();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int   n;
    logic nz;
    logic bad;

    reset   = 1'b1;
    in      = '0;
    load    = 1'b0;
    address = '0;
    clear   = 1'b0;

    // power-up reset and first full clear
    tick();
    reset = 1'b0;
    chk("reset_busy", busy, 1);
    chk("reset_out", out, 0);
    wait_idle(n, nz);
    chk("init_busy_len", n, 64);
    chk("init_out_zero", nz, 0);
    chk("init_busy_low", busy, 0);
    bad = 1'b0;
    for (int a = 0; a < 64; a++) begin
      address = 6'(a);
      #1;
      if (out !== 16'h0) bad = 1'b1;
    end
    chk("init_all_zero", bad, 0);

    vt.push_back('{1, 0,  7, 16'hBEEF, 16'h0000, 16'hBEEF, 0});
    vt.push_back('{1, 0,  8, 16'h1234, 16'h0000, 16'h1234, 0});
    vt.push_back('{1, 0, 63, 16'hFFFF, 16'h0000, 16'hFFFF, 0});
    vt.push_back('{0, 0, 15, 16'h0000, 16'h0000, 16'h0000, 0});
    vt.push_back('{0, 0,  7, 16'h0000, 16'hBEEF, 16'hBEEF, 0});
    vt.push_back('{0, 0, 63, 16'h0000, 16'hFFFF, 16'hFFFF, 0});
    vt.push_back('{0, 0,  8, 16'h0000, 16'h1234, 16'h1234, 0});
    vt.push_back('{1, 0, 10, 16'h00C3, 16'h0000, 16'h00C3, 0});
    vt.push_back('{1, 0, 10, 16'h0F0F, 16'h00C3, 16'h0F0F, 0});
    vt.push_back('{0, 0, 15, 16'h0000, 16'h0000, 16'h0000, 0});
    vt.push_back('{1, 1,  3, 16'h5555, 16'h0000, 16'h0000, 1});

    foreach (vt[i]) begin
      load    = vt[i].ld;
      clear   = vt[i].clr;
      address = vt[i].addr;
      in      = vt[i].din;
      #1;
      chk($sformatf("vec%0d_pre", i), out, vt[i].pre);
      tick();
      chk($sformatf("vec%0d_busy", i), busy, vt[i].bsy);
      chk($sformatf("vec%0d_post", i), out, vt[i].post);
    end
    load  = 1'b0;
    clear = 1'b0;

    // clear won over load in the last vector
    wait_idle(n, nz);
    chk("clr_busy_len", n, 64);
    address = 6'd3;
    #1;
    chk("clr_addr3", out, 0);
    address = 6'd7;
    #1;
    chk("clr_addr7", out, 0);

    // load while busy is ignored
    do_reset();
    load    = 1'b1;
    address = 6'd5;
    in      = 16'hAAAA;
    wait_idle(n, nz);
    load = 1'b0;
    chk("busyload_len", n, 64);
    chk("busyload_out0", nz, 0);
    #1;
    chk("busyload_addr5", out, 0);

    // first honoured load right after busy drops
    load    = 1'b1;
    address = 6'd20;
    in      = 16'h7E57;
    tick();
    load = 1'b0;
    chk("first_load", out, 16'h7E57);

    // fill, clear, then reset 20 cycles in
    for (int a = 0; a < 64; a++) begin
      load    = 1'b1;
      address = 6'(a);
      in      = 16'(a);
      tick();
    end
    load    = 1'b0;
    address = 6'd40;
    #1;
    chk("fill_40", out, 16'd40);
    address = 6'd63;
    #1;
    chk("fill_63", out, 16'd63);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("fill_clr_busy", busy, 1);
    for (int k = 0; k < 20; k++) tick();
    do_reset();
    wait_idle(n, nz);
    chk("restart_len", n, 64);
    bad = 1'b0;
    for (int a = 0; a < 64; a++) begin
      address = 6'(a);
      #1;
      if (out !== 16'h0) bad = 1'b1;
    end
    chk("restart_all_zero", bad, 0);

    // clear held 3 cycles: one sweep only
    clear = 1'b1;
    tick();
    tick();
    tick();
    clear = 1'b0;
    wait_idle(n, nz);
    chk("held_clr_len", n, 62);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ram_clr.md
# ram_clr

Parametrised banked read/write memory; the successor to the fixed 64-word, 16-bit RAM block. Word width, depth and bank count are set by parameters. Read is combinational. An internal clear sequencer zeroes every word after reset, or on request, and raises `busy` while it runs. It sits in the data-memory path between the CPU and the memory-mapped I/O decode.

## Interface
Parameters:
- `WIDTH`, 16, data word width in bits.
- `ADDR_W`, 6, address width; DEPTH = 2**ADDR_W words.
- `BANK_W`, 3, bank-select bits (upper address bits); 2**BANK_W banks of 2**(ADDR_W-BANK_W) words; legal range 0..ADDR_W.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset; starts a full clear.
- `in`  in  WIDTH  write data.
- `load`  in  1  write enable; honoured only when not busy.
- `address`  in  ADDR_W  read/write word address.
- `clear`  in  1  single-cycle request to zero the whole array; honoured only in IDLE.
- `out`  out  WIDTH  read data.
- `busy`  out  1  high while the clear sequencer owns the array.

## Operation
- States:
  - IDLE: normal access.
  - CLEAR: sequencer writes 0 to `mem[cnt]`; `cnt` is ADDR_W bits.
- Reset edge (any state, including mid-clear):
  - state <= CLEAR, cnt <= 0.
  - Any in-progress clear restarts from word 0.
  - Any `load` in that cycle is dropped.
- CLEAR, each edge:
  - mem[cnt] <= 0.
  - If cnt == DEPTH-1: state <= IDLE. Otherwise cnt <= cnt+1.
  - `load` and `clear` are ignored.
- IDLE, each edge:
  - If `clear`: state <= CLEAR, cnt <= 0, no write. `clear` beats `load` when both are high.
  - Else if `load`: mem[address] <= in.
- Read path:
  - `out` = mem[address] combinationally when state == IDLE.
  - `out` = 0 while busy.
- `busy` = (state == CLEAR), decoded directly from the state register.
- Bank decode:
  - address[ADDR_W-1 : ADDR_W-BANK_W] selects the bank; the lower bits select the word in the bank.
  - The write enable goes to exactly one bank.
  - During CLEAR, `cnt` replaces `address` for both decode and write.
- Before the first reset, contents and state are undefined. The integration requirement is that `reset` is asserted at power-up.

## Timing
- Reset values, after the reset edge: state CLEAR, cnt 0, `busy` 1, `out` 0.
- Clear duration: exactly DEPTH cycles.
  - `busy` is high for DEPTH edges after the reset/clear edge.
  - The first honoured `load` is at edge DEPTH+1 counted from the reset edge (reset edge = edge 0).
- Write latency:
  - The new value is visible on `out` in the cycle after the write edge.
  - In the write cycle itself, `out` shows the old contents. There is no write-through bypass.
- Read latency: 0 cycles (combinational from `address`) in IDLE.
- `clear` pulse held for several cycles: only the first cycle acts; later cycles fall in CLEAR and are ignored. Held through to IDLE, it starts another clear.
- Counter wrap: `cnt` never wraps, because the transition to IDLE happens at DEPTH-1.

## Structure
- Shared package `ram_pkg`:
  - state encoding `ST_IDLE = 1'b0`, `ST_CLEAR = 1'b1`.
  - helper constant for DEPTH derivation.
- Sub-module `ram_bank`:
  - parameters WIDTH, ADDR_W-BANK_W.
  - ports clk, load, address, in, out.
  - no reset; zeroing is done only by sequencer writes.
- Top level contains:
  - generate loop instantiating 2**BANK_W `ram_bank` instances.
  - one-hot load decoder.
  - output mux.
  - FSM and counter.
  - address/data mux that selects cnt/0 during CLEAR.

## Test plan
All scenarios use WIDTH=16, ADDR_W=6, BANK_W=3.
- Reset, then idle 64 cycles:
  - `busy` is 1 for exactly 64 cycles, then 0.
  - `out` is 0 throughout.
  - Every address then reads 0x0000.
- After clear, write 0xBEEF@7, 0x1234@8, 0xFFFF@63:
  - Each reads back correctly on the next cycle.
  - Address 15 still reads 0.
  - Bank isolation holds: the write @7 does not affect 15 or 63.
- `load`=1 with 0xAAAA@5 while busy: ignored; address 5 reads 0 after clear completes.
- `load`=1 with 0x5555@3 and `clear`=1 in the same IDLE cycle:
  - Clear wins; `busy` rises next cycle.
  - After 64 cycles, address 3 reads 0.
- Fill all 64 words with value = address. Pulse `reset` 20 cycles into a `clear`:
  - Clear restarts; `busy` stays high 64 cycles from the reset edge.
  - All words read 0 afterwards.
- Write 0x00C3@10, then drive address=10 with `load`=1, in=0x0F0F:
  - Same-cycle `out` = 0x00C3.
  - Next cycle `out` = 0x0F0F.
